// File: rtl/event_encoder_8x3_if.sv
// Output handshake bundle for the 8-to-3 event encoder.
// Signals:
//   code  - 3-bit index of the event being presented
//   valid - code is meaningful
//   ready - consumer accepts code when valid && ready at a rising edge
// Modports:
//   master - the encoder side (drives code/valid, samples ready)
//   slave  - the consumer side (samples code/valid, drives ready)
interface event_encoder_8x3_if;
    logic [2:0] code;
    logic       valid;
    logic       ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/event_encoder_8x3.sv
// Sequential 8-to-3 event encoder.
// Single-cycle strobes on d are latched into a pending register. Pending
// events are handed out one per accepted transfer as a 3-bit index on a
// valid/ready slot, highest index first. A strobe that lands on a bit that
// is already pending, and is not being loaded on that edge, is a lost event.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   en       - capture enable; d is ignored while low
//   d[7:0]   - event strobes
//   bus      - code/valid/ready handshake (master side)
//   pending  - events captured but not yet loaded into code
//   overflow - one-cycle pulse after an edge that lost at least one event
//   ovf_cnt  - saturating count of edges that lost events
module event_encoder_8x3 #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0]           d,
    event_encoder_8x3_if.master  bus,
    output logic [7:0]           pending,
    output logic                 overflow,
    output logic [CNT_W-1:0]     ovf_cnt
);

    logic [7:0]       pending_reg;
    logic [2:0]       code_reg;
    logic             valid_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] ovf_cnt_reg;

    logic [7:0]       cap;
    logic             slot_free;
    logic [2:0]       hi_idx;
    logic             do_load;
    logic [7:0]       load_vec;
    logic [7:0]       lost_vec;
    logic [7:0]       pending_next;

    assign cap       = d & {8{en}};
    // ready only steers the next state; outputs come straight from registers.
    assign slot_free = !valid_reg || bus.ready;
    assign do_load   = slot_free && (pending_reg != 8'h00);

    // Fixed priority: the last set bit scanned upward wins, so bit 7 dominates.
    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_reg[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign load_vec[gi]     = do_load && (hi_idx == 3'(gi));
            // A new strobe beats the clear of a bit being loaded this edge.
            assign pending_next[gi] = cap[gi] | (pending_reg[gi] & ~load_vec[gi]);
            assign lost_vec[gi]     = cap[gi] & pending_reg[gi] & ~load_vec[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg  <= 8'h00;
            code_reg     <= 3'd0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            ovf_cnt_reg  <= '0;
        end else begin
            pending_reg <= pending_next;
            if (slot_free) begin
                valid_reg <= do_load;
                if (do_load) begin
                    code_reg <= hi_idx;
                end
            end
            // Several colliding bits on one edge still count as one loss.
            overflow_reg <= |lost_vec;
            if ((|lost_vec) && (ovf_cnt_reg != {CNT_W{1'b1}})) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end
        end
    end

    assign pending   = pending_reg;
    assign bus.code  = code_reg;
    assign bus.valid = valid_reg;
    assign overflow  = overflow_reg;
    assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: tb/tb_event_encoder_8x3.sv
module tb_event_encoder_8x3;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [7:0]       d;
    logic [7:0]       pending;
    logic             overflow;
    logic [CNT_W-1:0] ovf_cnt;

    event_encoder_8x3_if bus ();

    event_encoder_8x3 #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d        (d),
        .bus      (bus),
        .pending  (pending),
        .overflow (overflow),
        .ovf_cnt  (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a set of pending event numbers plus the presented slot.
    bit m_pend [8];
    int m_code;
    bit m_valid;
    bit m_ovf;
    int m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_code  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_cnt   = 0;
    endfunction

    // One clock edge of the specified behaviour.
    function automatic void model_edge(input bit e, input bit [7:0] dv, input bit rdy);
        int  take;
        bit  lost;
        bit  slot_open;
        slot_open = !m_valid || rdy;
        take = -1;
        if (slot_open) begin
            for (int i = 7; i >= 0; i--) begin
                if (m_pend[i] && take < 0) take = i;
            end
        end
        lost = 0;
        for (int i = 0; i < 8; i++) begin
            if (e && dv[i] && m_pend[i] && i != take) lost = 1;
        end
        if (take >= 0) m_pend[take] = 0;
        for (int i = 0; i < 8; i++) begin
            if (e && dv[i]) m_pend[i] = 1;
        end
        if (slot_open) begin
            if (take >= 0) begin
                m_code  = take;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf = lost;
        if (lost && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    endfunction

    function automatic int model_pending();
        int v;
        v = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) v = v + (1 << i);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".code"},     32'(bus.code),  32'(m_code));
        check({tag, ".valid"},    32'(bus.valid), 32'(m_valid));
        check({tag, ".pending"},  32'(pending),   32'(model_pending()));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),   32'(m_cnt));
        $display("%s en=%0b d=%02h ready=%0b -> code=%0d valid=%0b pending=%02h ovf=%0b cnt=%0d",
                 tag, en, d, bus.ready, bus.code, bus.valid, pending, overflow, ovf_cnt);
    endtask

    // Called at posedge+1: drive inputs, advance one edge, compare at posedge+1.
    task automatic step(input string tag, input bit e, input bit [7:0] dv, input bit rdy);
        en        = e;
        d         = dv;
        bus.ready = rdy;
        @(posedge clk);
        model_edge(e, dv, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        d         = 8'h00;
        bus.ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) step("idle", 1, 8'h00, 1);
        check("idle.code_zero", 32'(bus.code), 32'd0);

        // Single event, ready held high.
        step("single.t", 1, 8'h10, 1);
        check("single.pend_t1", 32'(pending), 32'h10);
        step("single.t1", 1, 8'h00, 1);
        check("single.code4", 32'(bus.code), 32'd4);
        check("single.valid", 32'(bus.valid), 32'd1);
        step("single.t2", 1, 8'h00, 1);
        check("single.drained", 32'(bus.valid), 32'd0);

        // Priority drain with ready high.
        step("drain.cap", 1, 8'h85, 1);
        step("drain.c7", 1, 8'h00, 1);
        check("drain.code7", 32'(bus.code), 32'd7);
        step("drain.c2", 1, 8'h00, 1);
        check("drain.code2", 32'(bus.code), 32'd2);
        step("drain.c0", 1, 8'h00, 1);
        check("drain.code0", 32'(bus.code), 32'd0);
        step("drain.idle", 1, 8'h00, 1);

        // Same drain with backpressure.
        step("bp.cap", 1, 8'h85, 0);
        step("bp.load7", 1, 8'h00, 0);
        for (int i = 0; i < 3; i++) step("bp.hold", 1, 8'h00, 0);
        check("bp.code_held", 32'(bus.code), 32'd7);
        step("bp.c2", 1, 8'h00, 1);
        step("bp.c0", 1, 8'h00, 1);
        check("bp.code0", 32'(bus.code), 32'd0);
        step("bp.idle", 1, 8'h00, 1);

        // Overflow with code 7 held.
        step("ovf.cap7", 1, 8'h80, 0);
        step("ovf.load7", 1, 8'h00, 0);
        step("ovf.t", 1, 8'h01, 0);
        step("ovf.t1", 1, 8'h01, 0);
        check("ovf.pulse", 32'(overflow), 32'd1);
        check("ovf.cnt1", 32'(ovf_cnt), 32'd1);
        step("ovf.t2", 1, 8'h00, 0);
        check("ovf.pulse_end", 32'(overflow), 32'd0);
        for (int i = 0; i < 260; i++) step("ovf.sat", 1, 8'h01, 0);
        check("ovf.saturated", 32'(ovf_cnt), 32'hFF);

        // Drain, then simultaneous set and clear of bit 3.
        for (int i = 0; i < 3; i++) step("sc.drain", 1, 8'h00, 1);
        step("sc.cap", 1, 8'h08, 1);
        step("sc.load", 1, 8'h08, 1);
        check("sc.code3", 32'(bus.code), 32'd3);
        check("sc.pend_kept", 32'(pending), 32'h08);
        step("sc.again", 1, 8'h00, 1);
        check("sc.code3_again", 32'(bus.code), 32'd3);
        step("sc.idle", 1, 8'h00, 1);

        // Capture disabled.
        step("en.off", 0, 8'hFF, 1);
        check("en.no_pend", 32'(pending), 32'h00);

        // Reset while a code is held.
        step("mid.cap", 1, 8'hC0, 0);
        step("mid.load", 1, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid.rst");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("mid.after", 1, 8'h00, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit [7:0] rd;
            rd = 8'($urandom) & 8'($urandom);
            step("rand", ($urandom_range(0, 7) != 0), rd, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
